// File: rtl/ram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram_port_arbiter: shares one stall-handshake RAM port among N masters,   |
// | fixed-priority or round-robin, with a registered grant.  Rev 1.0         |
// +--------------------------------------------------------------------------+
module ram_port_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 24,
  parameter int DATA_WIDTH  = 32,
  parameter int RR_MODE     = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_address,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_wrdata,
  input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] m_byteenable,
  input  logic [NUM_MASTERS-1:0]                m_read,
  input  logic [NUM_MASTERS-1:0]                m_write,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_rddata,
  output logic [NUM_MASTERS-1:0]                m_stall,
  output logic [ADDR_WIDTH-1:0]                 s_address,
  output logic [DATA_WIDTH-1:0]                 s_wrdata,
  output logic [DATA_WIDTH/8-1:0]               s_byteenable,
  output logic                                  s_read,
  output logic                                  s_write,
  input  logic [DATA_WIDTH-1:0]                 s_rddata,
  input  logic                                  s_stall
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int GW       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [GW-1:0]          g_q, g_d, p_q, p_d;
  logic [NUM_MASTERS-1:0] req, cand, g_onehot;
  logic [GW-1:0]          g_inc, base, win;
  logic                   busy, req_g, found;
  int                     idx;

  always_comb begin
    req      = m_read | m_write;
    g_onehot = '0;
    for (int i = 0; i < NUM_MASTERS; i++) g_onehot[i] = (g_q == GW'(i));
    g_inc = (int'(g_q) == NUM_MASTERS - 1) ? '0 : g_q + GW'(1);
    busy  = (state_q == BUSY);
    req_g = |(req & g_onehot);
  end

  // On a completion the finishing master is excluded and the search starts at the updated pointer.
  always_comb begin
    cand  = busy ? (req & ~g_onehot) : req;
    base  = '0;
    if (RR_MODE != 0) base = busy ? g_inc : p_q;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = int'(base) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      for (int j = 0; j < NUM_MASTERS; j++) begin
        if (!found && (j == idx) && cand[j]) begin
          found = 1'b1;
          win   = GW'(j);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          g_d     = win;
        end
      end
      BUSY: begin
        if (!req_g) begin
          state_d = IDLE;
        end else if (!s_stall) begin
          p_d = g_inc;
          if (found) g_d = win;
          else       state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      g_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      p_q     <= p_d;
    end
  end

  always_comb begin
    s_address    = '0;
    s_wrdata     = '0;
    s_byteenable = '0;
    s_read       = 1'b0;
    s_write      = 1'b0;
    m_rddata     = '0;
    m_stall      = req;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (busy && g_onehot[i]) begin
        s_address    = m_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        s_wrdata     = m_wrdata[i*DATA_WIDTH +: DATA_WIDTH];
        s_byteenable = m_byteenable[i*BE_WIDTH +: BE_WIDTH];
        s_write      = m_write[i];
        s_read       = m_read[i] & ~m_write[i];
        m_rddata[i*DATA_WIDTH +: DATA_WIDTH] = s_rddata;
        m_stall[i]   = req[i] & s_stall;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Parametrised N-master arbiter that shares one stall-handshake RAM port (the dram_adapter port style: address, byteenable, read, write, wrdata, rddata, stall) among several bus masters. It generalises the fixed two-port ibus/dbus RAM sharing:

- configurable master count and widths;
- selectable fixed-priority or round-robin policy;
- registered grant state machine.

It sits between the ibus/dbus RAM outputs (plus any future DMA/GPU masters) and a single-port RAM controller.

## Interface
- NUM_MASTERS, 2, number of masters, legal 1..8
- ADDR_WIDTH, 24, word-address bus width
- DATA_WIDTH, 32, data width; byteenable width is DATA_WIDTH/8
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (master 0 highest)

Ports:
- clk  in  1  bus clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- m_address  in  NUM_MASTERS*ADDR_WIDTH  master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- m_wrdata  in  NUM_MASTERS*DATA_WIDTH  per-master write data
- m_byteenable  in  NUM_MASTERS*DATA_WIDTH/8  per-master byte enables
- m_read  in  NUM_MASTERS  per-master read request
- m_write  in  NUM_MASTERS  per-master write request
- m_rddata  out  NUM_MASTERS*DATA_WIDTH  per-master read data
- m_stall  out  NUM_MASTERS  per-master stall
- s_address  out  ADDR_WIDTH  to RAM controller
- s_wrdata  out  DATA_WIDTH  to RAM controller
- s_byteenable  out  DATA_WIDTH/8  to RAM controller
- s_read  out  1  to RAM controller
- s_write  out  1  to RAM controller
- s_rddata  in  DATA_WIDTH  from RAM controller
- s_stall  in  1  from RAM controller; low = current transfer completes this cycle

## Operation
- **Request definition:** req[i] = m_read[i] | m_write[i].
- **Master protocol:** a master holds its request fields stable until a cycle with m_stall[i]=0; that cycle completes the transfer.
- **States:** IDLE, BUSY. Registers: grant index g (clog2(NUM_MASTERS), min 1 bit), rr pointer p.
- **IDLE:**
  - If any req, select a winner, latch it into g, and move to BUSY next cycle.
  - No slave request is driven in IDLE.
- **Selection policy:**
  - RR_MODE=0: lowest requesting index.
  - RR_MODE=1: first requesting index searching p, p+1, ... modulo NUM_MASTERS.
- **BUSY:**
  - Slave outputs mux master g's address, wrdata, byteenable, read and write.
  - If m_read[g] and m_write[g] are both high, s_write=1 and s_read=0 (write wins).
- **Completion:** BUSY, req[g]=1 and s_stall=0.
  - m_stall[g]=0 and m_rddata[g]=s_rddata in that cycle.
  - p <= (g+1) mod NUM_MASTERS.
  - Re-arbitrate in the same cycle among requesting masters excluding g (g's current request is the finished one).
  - If a winner exists, latch it into g and stay BUSY; otherwise go to IDLE.
  - A lone master therefore gets at most one transfer per two cycles.
- **Granted master drops its request** (req[g]=0 in BUSY; protocol violation): slave read/write forward low that cycle, return to IDLE, p unchanged.
- **m_stall[i]:** equals req[i] & ~(BUSY & g==i & ~s_stall). Non-requesting masters see 0.
- **m_rddata[i]:** equals s_rddata when BUSY and g==i, otherwise 0.
- **Idle slave outputs:** in IDLE all slave outputs are 0.
- **Structure:** outputs are combinational from registered state plus inputs; only state, g and p are registered.

## Timing
- **Reset values:** rst_n low asynchronously forces IDLE, g=0, p=0.
  - Consequently s_read, s_write, s_address, s_wrdata, s_byteenable and all m_rddata are 0.
  - m_stall = req (combinational).
- **Arbitration latency:** a request first seen in IDLE at cycle n is driven to the slave at cycle n+1.
  - Minimum completion is cycle n+1 if s_stall=0, which gives a 2-cycle minimum transfer.
- **Reset mid-BUSY:** slave requests drop in the same cycle (asynchronous). The RAM controller must tolerate an aborted request.
- **Rr pointer wrap:** p wraps from NUM_MASTERS-1 to 0.
- **NUM_MASTERS=1:** g and p stay 0; behaviour is pass-through plus the one-cycle IDLE/BUSY bubble.
- **Back-to-back handover:** a completion with another master waiting hands over with no IDLE cycle; the new master is driven to the slave the next cycle.
- **Stability:** s_address and the other slave fields are stable throughout BUSY while s_stall=1, provided the master obeys the protocol.

## Test plan
- **Single read:** NUM_MASTERS=2, m0 read addr 0x000010; s_stall high 2 cycles then low with s_rddata=0xDEADBEEF -> s_read high cycles 1-3; m_stall[0] low and m_rddata[0]=0xDEADBEEF at cycle 3; IDLE at cycle 4.
- **Round-robin:** RR_MODE=1, m0 and m1 both continuously request, s_stall=0 -> grants alternate 0,1,0,1 with no IDLE cycles between transfers.
- **Fixed priority:** RR_MODE=0, NUM_MASTERS=3, all three continuously request -> first grant 0; the completion handover never selects the finishing master, so the sequence is 0,1,0,1; master 2 is served only when 0 and 1 are idle.
- **Wrap-around:** RR_MODE=1, NUM_MASTERS=3, p=2 after serving m1, with m0 and m2 requesting -> m2 granted, then p=0 and m0 granted.
- **Write precedence:** m0 asserts read and write with wrdata 0x12345678, byteenable 4'b0011 -> s_write=1, s_read=0, s_wrdata=0x12345678, s_byteenable=4'b0011.
- **Reset mid-BUSY:** rst_n low while s_stall=1 during an m1 transfer -> s_read, s_write and all slave outputs are 0 in the same cycle; after release, the first grant follows priority with p=0.
